// File: rtl/audio_chan_serializer_pkg.sv
// Shared audio definitions: default channel count and sample width, the
// sample type, and the frame serializer FSM state encoding.
package audio_chan_serializer_pkg;

  localparam int unsigned AUDIO_WIDTH        = 24;
  localparam int unsigned NUM_AUDIO_CHANNELS = 8;

  typedef logic [AUDIO_WIDTH-1:0] sample_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    POP    = 2'd1,
    WAIT   = 2'd2,
    STREAM = 2'd3
  } state_t;

endpackage

// File: rtl/audio_chan_serializer.sv
// Pops one parallel audio frame from the upstream input buffer, holds it in
// a frame register, and streams it out one channel per beat with ready/valid
// flow control.
//
// Ports:
//   sys_clk          sole clock, rising edge
//   sys_rst          synchronous active-high reset
//   buffer_ready     upstream buffer holds at least one unread frame
//   adv_read_enable  one-cycle pop pulse to the upstream buffer
//   audio_channel_in parallel frame from the upstream buffer
//   m_data/m_chan    serialized sample and its channel index
//   m_last           final channel of the frame
//   m_valid/m_ready  beat handshake
//   busy             frame in progress
//   frame_count      completed frames, modulo 2^16
module audio_chan_serializer #(
  parameter int unsigned NUM_AUDIO_CHANNELS = audio_chan_serializer_pkg::NUM_AUDIO_CHANNELS,
  parameter int unsigned AUDIO_WIDTH        = audio_chan_serializer_pkg::AUDIO_WIDTH,
  parameter int unsigned READ_LATENCY       = 1,
  localparam int unsigned CHAN_W            = $clog2(NUM_AUDIO_CHANNELS)
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst,
  input  logic                   buffer_ready,
  output logic                   adv_read_enable,
  input  logic [AUDIO_WIDTH-1:0] audio_channel_in [NUM_AUDIO_CHANNELS],
  output logic [AUDIO_WIDTH-1:0] m_data,
  output logic [CHAN_W-1:0]      m_chan,
  output logic                   m_last,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic                   busy,
  output logic [15:0]            frame_count
);

  import audio_chan_serializer_pkg::*;

  localparam int unsigned WAIT_W = 3;
  localparam logic [CHAN_W-1:0] LAST_IDX = CHAN_W'(NUM_AUDIO_CHANNELS - 1);
  localparam logic [WAIT_W-1:0] WAIT_END = WAIT_W'(READ_LATENCY - 1);

  state_t                 state, state_next;
  logic [WAIT_W-1:0]      wait_cnt, wait_next;
  logic [AUDIO_WIDTH-1:0] frame      [NUM_AUDIO_CHANNELS];
  logic [AUDIO_WIDTH-1:0] frame_next [NUM_AUDIO_CHANNELS];
  logic [CHAN_W-1:0]      idx_next;
  logic [CHAN_W-1:0]      idx_inc_c;
  logic [AUDIO_WIDTH-1:0] data_next;
  logic                   valid_next;
  logic                   last_next;
  logic                   adv_next;
  logic                   busy_next;
  logic [15:0]            count_next;

  // m_chan doubles as the channel index register.
  assign idx_inc_c = m_chan + 1'b1;

  // Next-state and next-output logic; every output is a register loaded
  // from the value it must show in the coming state.
  always_comb begin
    state_next = state;
    wait_next  = wait_cnt;
    frame_next = frame;
    idx_next   = m_chan;
    data_next  = m_data;
    valid_next = 1'b0;
    last_next  = 1'b0;
    adv_next   = 1'b0;
    count_next = frame_count;

    case (state)
      IDLE: begin
        if (buffer_ready) begin
          state_next = POP;
          adv_next   = 1'b1;
        end
      end

      POP: begin
        state_next = WAIT;
        wait_next  = '0;
      end

      WAIT: begin
        if (wait_cnt == WAIT_END) begin
          // Read data is valid now regardless of buffer_ready.
          state_next = STREAM;
          frame_next = audio_channel_in;
          idx_next   = '0;
          data_next  = audio_channel_in[0];
          valid_next = 1'b1;
        end else begin
          wait_next = wait_cnt + 1'b1;
        end
      end

      STREAM: begin
        valid_next = 1'b1;
        last_next  = m_last;
        if (m_ready) begin
          if (m_chan == LAST_IDX) begin
            state_next = IDLE;
            idx_next   = '0;
            valid_next = 1'b0;
            last_next  = 1'b0;
            count_next = frame_count + 16'd1;
          end else begin
            idx_next  = idx_inc_c;
            data_next = frame[idx_inc_c];
            last_next = (idx_inc_c == LAST_IDX);
          end
        end
      end

      default: state_next = IDLE;
    endcase

    busy_next = (state_next != IDLE);
  end

  // State and output registers.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state           <= IDLE;
      wait_cnt        <= '0;
      frame           <= '{default: '0};
      m_chan          <= '0;
      m_data          <= '0;
      m_valid         <= 1'b0;
      m_last          <= 1'b0;
      adv_read_enable <= 1'b0;
      busy            <= 1'b0;
      frame_count     <= '0;
    end else begin
      state           <= state_next;
      wait_cnt        <= wait_next;
      frame           <= frame_next;
      m_chan          <= idx_next;
      m_data          <= data_next;
      m_valid         <= valid_next;
      m_last          <= last_next;
      adv_read_enable <= adv_next;
      busy            <= busy_next;
      frame_count     <= count_next;
    end
  end

endmodule

// File: tb/tb_audio_chan_serializer.sv
// Directed bench for audio_chan_serializer with default parameters
// (8 channels, 24-bit samples, read latency 1).
module tb_audio_chan_serializer;

  localparam int unsigned N  = 8;
  localparam int unsigned W  = 24;
  localparam int unsigned RL = 1;
  localparam int unsigned CW = 3;

  logic          sys_clk = 1'b0;
  logic          sys_rst;
  logic          buffer_ready;
  logic          adv_read_enable;
  logic [W-1:0]  audio_channel_in [N];
  logic [W-1:0]  m_data;
  logic [CW-1:0] m_chan;
  logic          m_last;
  logic          m_valid;
  logic          m_ready;
  logic          busy;
  logic [15:0]   frame_count;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int pop_times[$];

  audio_chan_serializer #(
    .NUM_AUDIO_CHANNELS(N),
    .AUDIO_WIDTH       (W),
    .READ_LATENCY      (RL)
  ) dut (
    .sys_clk         (sys_clk),
    .sys_rst         (sys_rst),
    .buffer_ready    (buffer_ready),
    .adv_read_enable (adv_read_enable),
    .audio_channel_in(audio_channel_in),
    .m_data          (m_data),
    .m_chan          (m_chan),
    .m_last          (m_last),
    .m_valid         (m_valid),
    .m_ready         (m_ready),
    .busy            (busy),
    .frame_count     (frame_count)
  );

  always #5 sys_clk = ~sys_clk;

  // Record the cycle of every pop the upstream buffer would see.
  always @(posedge sys_clk) begin
    cyc++;
    if (adv_read_enable === 1'b1) pop_times.push_back(cyc);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_lanes(input int unsigned base);
    for (int unsigned i = 0; i < N; i++) audio_channel_in[i] = W'(base + i);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (m_valid !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk(tag, 32'(m_valid), 32'd1);
  endtask

  // Checks beats [from, to) of a frame whose lane i holds base+i, with
  // m_ready held high so each beat transfers on the following edge.
  task automatic beats(input string tag, input int unsigned base,
                       input int unsigned from, input int unsigned to);
    for (int unsigned k = from; k < to; k++) begin
      chk({tag, "_valid"}, 32'(m_valid), 32'd1);
      chk({tag, "_data"},  32'(m_data),  32'(base + k));
      chk({tag, "_chan"},  32'(m_chan),  32'(k));
      chk({tag, "_last"},  32'(m_last),  32'(k == N - 1));
      step();
    end
  endtask

  initial begin
    sys_rst      = 1'b1;
    buffer_ready = 1'b0;
    m_ready      = 1'b0;
    set_lanes(0);

    // Reset held for three cycles.
    repeat (3) step();
    chk("rst_adv",   32'(adv_read_enable), 32'd0);
    chk("rst_valid", 32'(m_valid),         32'd0);
    chk("rst_last",  32'(m_last),          32'd0);
    chk("rst_busy",  32'(busy),            32'd0);
    chk("rst_count", 32'(frame_count),     32'd0);
    chk("rst_data",  32'(m_data),          32'd0);
    chk("rst_chan",  32'(m_chan),          32'd0);
    sys_rst = 1'b0;
    step();
    chk("idle_busy", 32'(busy), 32'd0);

    // Mid-frame reset at channel 4.
    set_lanes(32'h200000);
    m_ready      = 1'b1;
    buffer_ready = 1'b1;
    step();
    buffer_ready = 1'b0;
    chk("mrst_pop", 32'(adv_read_enable), 32'd1);
    wait_valid("mrst_wait");
    beats("mrst", 32'h200000, 0, 4);
    chk("mrst_chan4", 32'(m_chan), 32'd4);
    sys_rst = 1'b1;
    step();
    sys_rst = 1'b0;
    chk("mrst_valid", 32'(m_valid),     32'd0);
    chk("mrst_count", 32'(frame_count), 32'd0);
    chk("mrst_busy",  32'(busy),        32'd0);
    chk("mrst_last",  32'(m_last),      32'd0);

    // Single frame with exact pop-to-stream timing.
    pop_times.delete();
    set_lanes(32'h100000);
    buffer_ready = 1'b1;
    step();
    buffer_ready = 1'b0;
    chk("one_pop",       32'(adv_read_enable), 32'd1);
    chk("one_pop_busy",  32'(busy),            32'd1);
    chk("one_pop_valid", 32'(m_valid),         32'd0);
    step();
    chk("one_wait_adv",   32'(adv_read_enable), 32'd0);
    chk("one_wait_valid", 32'(m_valid),         32'd0);
    chk("one_wait_busy",  32'(busy),            32'd1);
    step();
    beats("one", 32'h100000, 0, N);
    chk("one_end_valid", 32'(m_valid),     32'd0);
    chk("one_end_busy",  32'(busy),        32'd0);
    chk("one_count",     32'(frame_count), 32'd1);
    repeat (3) step();
    chk("one_pops", 32'(pop_times.size()), 32'd1);

    // Backpressure for five cycles at channel 3.
    buffer_ready = 1'b1;
    step();
    buffer_ready = 1'b0;
    wait_valid("bp_wait");
    beats("bp", 32'h100000, 0, 3);
    m_ready = 1'b0;
    repeat (5) begin
      step();
      chk("bp_hold_valid", 32'(m_valid), 32'd1);
      chk("bp_hold_data",  32'(m_data),  32'h100003);
      chk("bp_hold_chan",  32'(m_chan),  32'd3);
      chk("bp_hold_last",  32'(m_last),  32'd0);
    end
    m_ready = 1'b1;
    beats("bp", 32'h100000, 3, N);
    chk("bp_count", 32'(frame_count), 32'd2);
    chk("bp_valid", 32'(m_valid),     32'd0);

    // Upstream data changes during STREAM must not reach the output.
    set_lanes(32'h300000);
    buffer_ready = 1'b1;
    step();
    buffer_ready = 1'b0;
    wait_valid("inchg_wait");
    beats("inchg", 32'h300000, 0, 1);
    for (int unsigned i = 0; i < N; i++) audio_channel_in[i] = 24'hABCDEF;
    beats("inchg", 32'h300000, 1, N);
    chk("inchg_count", 32'(frame_count), 32'd3);

    // Back-to-back frames with buffer_ready held high.
    pop_times.delete();
    set_lanes(32'h400000);
    buffer_ready = 1'b1;
    for (int f = 0; f < 3; f++) begin
      wait_valid("b2b_wait");
      if (f == 2) buffer_ready = 1'b0;
      beats("b2b", 32'h400000, 0, N);
    end
    repeat (4) step();
    chk("b2b_pops",  32'(pop_times.size()), 32'd3);
    if (pop_times.size() == 3) begin
      chk("b2b_gap1", 32'(pop_times[1] - pop_times[0]), 32'(2 + RL + N));
      chk("b2b_gap2", 32'(pop_times[2] - pop_times[1]), 32'(2 + RL + N));
    end
    chk("b2b_count", 32'(frame_count), 32'd6);
    chk("b2b_busy",  32'(busy),        32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/audio_chan_serializer.md
AUDIO_CHAN_SERIALIZER -- requirements
Module: audio_chan_serializer

Interface
REQ-001 Parameter NUM_AUDIO_CHANNELS, default 8: number of parallel channels taken from the input buffer; SHALL be at least 2.
REQ-002 Parameter AUDIO_WIDTH, default 24: bits per sample.
REQ-003 Parameter READ_LATENCY, default 1: cycles from an adv_read_enable pulse to valid audio_channel_in data; SHALL be between 1 and 4.
REQ-004 Derived CHAN_W = $clog2(NUM_AUDIO_CHANNELS).
REQ-005 Clocking and reset: one clock; reset is synchronous and active-high.
REQ-006 sys_clk  in  1  sole clock; all state updates on the rising edge.
REQ-007 sys_rst  in  1  synchronous, active-high reset.
REQ-008 buffer_ready  in  1  upstream buffer holds at least one unread frame.
REQ-009 adv_read_enable  out  1  one-cycle pulse that pops one frame from the upstream buffer.
REQ-010 audio_channel_in  in  [NUM_AUDIO_CHANNELS] x AUDIO_WIDTH  parallel frame presented by the upstream buffer.
REQ-011 m_data  out  AUDIO_WIDTH  serialized sample.
REQ-012 m_chan  out  CHAN_W  channel index of m_data.
REQ-013 m_last  out  1  high with the final channel of a frame.
REQ-014 m_valid  out  1  m_data, m_chan and m_last are valid.
REQ-015 m_ready  in  1  downstream accepts the beat.
REQ-016 busy  out  1  FSM is not in IDLE.
REQ-017 frame_count  out  16  completed frames, modulo 2^16.

Function
REQ-018 FSM states SHALL be IDLE, POP, WAIT, STREAM.
REQ-019 IDLE SHALL go to POP on the cycle after buffer_ready is sampled high, and SHALL otherwise remain in IDLE.
REQ-020 POP SHALL assert adv_read_enable for exactly one cycle, then go to WAIT.
REQ-021 adv_read_enable SHALL never be high in any state other than POP.
REQ-022 WAIT SHALL count READ_LATENCY cycles after the POP cycle.
REQ-023 On the last WAIT cycle, all audio_channel_in lanes SHALL be captured into an internal frame register.
REQ-024 After the capture, the FSM SHALL enter STREAM with the channel index at 0.
REQ-025 The capture SHALL occur even if buffer_ready falls during WAIT.
REQ-026 In STREAM, m_valid SHALL be 1, m_data SHALL equal frame[idx], and m_chan SHALL equal idx.
REQ-027 m_last SHALL equal (idx == NUM_AUDIO_CHANNELS-1) AND m_valid.
REQ-028 A beat transfers on m_valid AND m_ready.
REQ-029 While m_valid is high and m_ready is low, m_data, m_chan and m_last SHALL hold stable.
REQ-030 On a non-last transfer, idx SHALL increment by 1.
REQ-031 On the last transfer, frame_count SHALL increment, wrapping 0xFFFF to 0x0000, and the FSM SHALL return to IDLE.
REQ-032 Upstream changes to audio_channel_in during STREAM SHALL NOT affect m_data.
REQ-033 Minimum frame period with m_ready held high SHALL be 2 + READ_LATENCY + NUM_AUDIO_CHANNELS cycles, covering IDLE, POP, WAIT and the beats.
REQ-034 A frame in progress SHALL always complete; the module SHALL never pop while in WAIT or STREAM.
REQ-035 m_valid SHALL be 0 in IDLE, POP and WAIT.
REQ-036 busy SHALL be 1 in POP, WAIT and STREAM.

Reset
REQ-037 When sys_rst is sampled high, the FSM SHALL enter IDLE and idx SHALL become 0.
REQ-038 When sys_rst is sampled high, frame_count SHALL become 0 and the frame register SHALL be cleared to 0.
REQ-039 When sys_rst is sampled high, adv_read_enable, m_valid, m_last and busy SHALL become 0.
REQ-040 Reset during STREAM SHALL drop m_valid on the following cycle, abandon the frame, and SHALL NOT increment frame_count.
REQ-041 Reset on the POP cycle SHALL still let that adv_read_enable pulse register as a pop upstream; this is an accepted frame loss.

Structure
REQ-042 The shared audio package SHALL own AUDIO_WIDTH, NUM_AUDIO_CHANNELS, a sample typedef and the FSM state enum.
REQ-043 The FSM, index counter and frame register SHALL be implemented in one module with no sub-modules.
REQ-044 The module SHALL connect directly to the adv_read_enable, audio_channel_out and buffer_ready ports of buf_audio_in.

Verification
REQ-045 Reset: hold sys_rst 3 cycles -> all outputs 0 and frame_count 0.
REQ-046 Single frame: buffer_ready=1 for one frame, lane i = 0x100000+i, m_ready=1 -> exactly one adv_read_enable pulse; 8 beats with m_data 0x100000..0x100007 and m_chan 0..7; m_last only on beat 7; frame_count=1.
REQ-047 Backpressure: m_ready low for 5 cycles at idx 3 -> m_data holds 0x100003 with m_chan 3; no beat dropped or duplicated.
REQ-048 Back-to-back: buffer_ready held high, 3 frames -> 3 pops, each pop at least 11 cycles apart; frame_count=3.
REQ-049 Input change: alter audio_channel_in to 0xABCDEF during STREAM -> output keeps the captured values.
REQ-050 Mid-frame reset: assert sys_rst at idx 4 -> m_valid=0 next cycle; frame_count unchanged at 0; next frame restarts at m_chan 0.
